// File: rtl/buffer_loader_if.sv
// Loader-side bundle: controller request, input byte stream, buffer write port and router window.
// master = controller/stream/buffer/router environment, slave = the loader itself.
interface buffer_loader_if #(
  parameter int Depth     = 32,
  parameter int DataWidth = 8,
  parameter int AddrWidth = $clog2(Depth)
);
  logic                 start;
  logic [AddrWidth-1:0] baseAddr;
  logic [AddrWidth:0]   length;
  logic                 inValid;
  logic [DataWidth-1:0] inData;
  logic                 inReady;
  logic                 writeEn;
  logic [AddrWidth-1:0] writeAddr;
  logic [DataWidth-1:0] dataOut;
  logic                 routeEn;
  logic [AddrWidth-1:0] startAddr;
  logic [AddrWidth-1:0] finalAddr;
  logic                 routeFinished;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    output start, baseAddr, length, inValid, inData, routeFinished,
    input  inReady, writeEn, writeAddr, dataOut, routeEn, startAddr, finalAddr,
           busy, done, error
  );

  modport slave (
    input  start, baseAddr, length, inValid, inData, routeFinished,
    output inReady, writeEn, writeAddr, dataOut, routeEn, startAddr, finalAddr,
           busy, done, error
  );
endinterface

// File: rtl/buffer_loader.sv
// Loads length bytes into buffer[baseAddr..] then holds routeEn until routeFinished; write 1 cycle after beat, routeEn 2 after last beat, done 1 after finished.
// inReady is high for all of LOAD (no internal backpressure); LOADER_TIMEOUT_EN adds a route watchdog of TimeoutCycles.
module buffer_loader #(
  parameter int Depth     = 32,
  parameter int DataWidth = 8,
  parameter int AddrWidth = $clog2(Depth)
`ifdef LOADER_TIMEOUT_EN
  , parameter int TimeoutCycles = 64
`endif
) (
  input logic           clk,
  input logic           rst,
  buffer_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, ROUTE, DONE} state_t;

  localparam int CntW = AddrWidth + 1;
  localparam logic [AddrWidth+1:0] DepthW = (AddrWidth+2)'(Depth);

  state_t               state;
  logic [CntW-1:0]      count;
  logic [CntW-1:0]      lenQ;
  logic [CntW-1:0]      countNext;
  logic [AddrWidth+1:0] reqEnd;
  logic                 reqOk;
  logic                 beat;

  logic                 writeEnQ;
  logic [AddrWidth-1:0] writeAddrQ;
  logic [DataWidth-1:0] dataOutQ;
  logic                 routeEnQ;
  logic [AddrWidth-1:0] startAddrQ;
  logic [AddrWidth-1:0] finalAddrQ;
  logic                 doneQ;
  logic                 errorQ;

`ifdef LOADER_TIMEOUT_EN
  localparam int TmrW = $clog2(TimeoutCycles + 1);
  logic [TmrW-1:0] timer;
`endif

  // Extra headroom bit keeps baseAddr + length from wrapping before the Depth compare.
  assign reqEnd    = {2'b00, bus.baseAddr} + {1'b0, bus.length};
  assign reqOk     = (bus.length != '0) && (reqEnd <= DepthW);
  assign beat      = (state == LOAD) && bus.inValid;
  assign countNext = count + CntW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      lenQ       <= '0;
      writeEnQ   <= 1'b0;
      writeAddrQ <= '0;
      dataOutQ   <= '0;
      routeEnQ   <= 1'b0;
      startAddrQ <= '0;
      finalAddrQ <= '0;
      doneQ      <= 1'b0;
      errorQ     <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      writeEnQ <= 1'b0;
      doneQ    <= 1'b0;
      errorQ   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (reqOk) begin
              startAddrQ <= bus.baseAddr;
              finalAddrQ <= bus.baseAddr + bus.length[AddrWidth-1:0] - AddrWidth'(1);
              lenQ       <= bus.length;
              count      <= '0;
              state      <= LOAD;
            end else begin
              errorQ <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            writeEnQ   <= 1'b1;
            writeAddrQ <= startAddrQ + count[AddrWidth-1:0];
            dataOutQ   <= bus.inData;
            count      <= countNext;
            if (countNext == lenQ) state <= FLUSH;
          end
        end
        FLUSH: begin
          routeEnQ <= 1'b1;
          state    <= ROUTE;
`ifdef LOADER_TIMEOUT_EN
          timer    <= '0;
`endif
        end
        ROUTE: begin
          if (bus.routeFinished) begin
            routeEnQ <= 1'b0;
            doneQ    <= 1'b1;
            state    <= DONE;
`ifdef LOADER_TIMEOUT_EN
          end else if (timer == TmrW'(TimeoutCycles - 1)) begin
            routeEnQ <= 1'b0;
            errorQ   <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + TmrW'(1);
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inReady   = (state == LOAD);
  assign bus.busy      = (state != IDLE);
  assign bus.writeEn   = writeEnQ;
  assign bus.writeAddr = writeAddrQ;
  assign bus.dataOut   = dataOutQ;
  assign bus.routeEn   = routeEnQ;
  assign bus.startAddr = startAddrQ;
  assign bus.finalAddr = finalAddrQ;
  assign bus.done      = doneQ;
  assign bus.error     = errorQ;

endmodule

// File: tb/tb_buffer_loader.sv
// Scoreboard bench for buffer_loader: the driver pushes expected writes, route windows, done and error
// events with their cycle numbers; a negedge monitor pops and compares whatever the DUT presents.
module tb_buffer_loader;
  localparam int Depth     = 32;
  localparam int DataWidth = 8;
  localparam int AddrWidth = 5;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int sa; int fa; int cyc; } route_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prevRoute = 1'b0;

  wr_t    wrQ[$];
  route_t routeQ[$];
  int     doneQ[$];
  int     errQ[$];

  buffer_loader_if #(.Depth(Depth), .DataWidth(DataWidth)) bus();

  buffer_loader #(.Depth(Depth), .DataWidth(DataWidth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic unexpected(string name);
    checks++;
    errors++;
    $display("FAIL %s got event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every DUT event against the head of its expectation queue.
  initial begin
    wr_t    w;
    route_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prevRoute = 1'b0;
      end else begin
        if (bus.writeEn) begin
          if (wrQ.size() == 0) unexpected("write");
          else begin
            w = wrQ.pop_front();
            chk("wr_addr", int'(bus.writeAddr), w.addr);
            chk("wr_data", int'(bus.dataOut), w.data);
            chk("wr_cycle", cyc, w.cyc);
          end
        end
        if (bus.routeEn && !prevRoute) begin
          if (routeQ.size() == 0) unexpected("route_rise");
          else begin
            r = routeQ.pop_front();
            chk("route_start", int'(bus.startAddr), r.sa);
            chk("route_final", int'(bus.finalAddr), r.fa);
            chk("route_cycle", cyc, r.cyc);
          end
        end
        prevRoute = bus.routeEn;
        if (bus.done) begin
          if (doneQ.size() == 0) unexpected("done");
          else begin
            chk("done_cycle", cyc, doneQ.pop_front());
            chk("route_low_in_done", int'(bus.routeEn), 0);
          end
        end
        if (bus.error) begin
          if (errQ.size() == 0) unexpected("error");
          else chk("error_cycle", cyc, errQ.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: legal when length is nonzero and the window fits below Depth.
  task automatic issue(input int base, input int len, output bit ok);
    ok = (len != 0) && (base + len <= Depth);
    bus.start    = 1'b1;
    bus.baseAddr = base[AddrWidth-1:0];
    bus.length   = len[AddrWidth:0];
    if (!ok) errQ.push_back(cyc + 1);
    tick();
    bus.start = 1'b0;
    chk(ok ? "busy_after_accept" : "idle_after_reject", int'(bus.busy), ok ? 1 : 0);
  endtask

  // mode 0: continuous, 1: alternating 1,0,1,..., 2: random gaps.
  task automatic stream(input int base, input int len, input int mode, input bit rnd,
                        input int busyAt, output int lastBeat);
    int  i;
    int  d;
    bit  v;
    bit  tog;
    wr_t w;
    i = 0;
    tog = 1'b1;
    lastBeat = cyc;
    while (i < len) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = rnd ? int'($urandom_range(0, 255)) : 'h10 + i;
      bus.inValid = v;
      bus.inData  = d[DataWidth-1:0];
      bus.start   = (i == busyAt);
      if (i == busyAt) begin
        bus.baseAddr = 5'd20;
        bus.length   = 6'd5;
      end
      chk("ready_in_load", int'(bus.inReady), 1);
      if (v) begin
        w.addr = base + i;
        w.data = d;
        w.cyc  = cyc + 1;
        wrQ.push_back(w);
        lastBeat = cyc;
        i++;
      end
      tick();
    end
    bus.inValid = 1'b0;
    bus.start   = 1'b0;
    chk("ready_in_flush", int'(bus.inReady), 0);
    routeQ.push_back('{base, base + len - 1, lastBeat + 2});
  endtask

  task automatic finishRoute(input int atCyc, input bit startInDone);
    while (cyc < atCyc) tick();
    chk("route_up_before_finish", int'(bus.routeEn), 1);
    bus.routeFinished = 1'b1;
    doneQ.push_back(cyc + 1);
    tick();
    bus.routeFinished = 1'b0;
    if (startInDone) begin
      bus.start    = 1'b1;
      bus.baseAddr = 5'd0;
      bus.length   = 6'd4;
    end
    tick();
    bus.start = 1'b0;
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  initial begin
    bit ok;
    int lb;
    int n;
    int b;
    int l;
    bus.start = 1'b0;
    bus.baseAddr = '0;
    bus.length = '0;
    bus.inValid = 1'b0;
    bus.inData = '0;
    bus.routeFinished = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_writeEn", int'(bus.writeEn), 0);
    chk("rst_routeEn", int'(bus.routeEn), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_inReady", int'(bus.inReady), 0);
    chk("rst_startAddr", int'(bus.startAddr), 0);
    chk("rst_finalAddr", int'(bus.finalAddr), 0);
    rst = 1'b1;
    tick();

    // Basic load with a start in the DONE cycle that must be ignored.
    issue(4, 9, ok);
    stream(4, 9, 0, 1'b0, -1, lb);
    finishRoute(lb + 2 + 5, 1'b1);

    // Bubbled stream.
    issue(4, 9, ok);
    stream(4, 9, 1, 1'b0, -1, lb);
    finishRoute(lb + 4, 1'b0);

    // Illegal requests, then the full-depth window.
    issue(4, 0, ok);
    tick();
    issue(30, 3, ok);
    tick();
    issue(0, 32, ok);
    stream(0, 32, 2, 1'b1, -1, lb);
    finishRoute(lb + 3, 1'b0);

    // Start while busy is ignored.
    issue(4, 9, ok);
    stream(4, 9, 0, 1'b1, 3, lb);
    finishRoute(lb + 2, 1'b0);

    // Reset after 3 of 9 beats; the pending write must never appear.
    issue(4, 9, ok);
    for (int i = 0; i < 3; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = 8'(8'h40 + i);
      wrQ.push_back('{4 + i, 'h40 + i, cyc + 1});
      tick();
    end
    bus.inValid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_writeEn", int'(bus.writeEn), 0);
    chk("midrst_routeEn", int'(bus.routeEn), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_inReady", int'(bus.inReady), 0);
    wrQ.delete();
    tick();
    rst = 1'b1;
    tick();
    issue(4, 9, ok);
    stream(4, 9, 0, 1'b1, -1, lb);
    finishRoute(lb + 2, 1'b0);

    // Router never finishes.
    issue(8, 6, ok);
    stream(8, 6, 0, 1'b1, -1, lb);
    tick();
    n = 0;
`ifdef LOADER_TIMEOUT_EN
    errQ.push_back(lb + 2 + 64);
    for (int k = 0; k < 100 && bus.routeEn; k++) begin
      n++;
      tick();
    end
    chk("route_high_cycles", n, 64);
    chk("busy_after_timeout", int'(bus.busy), 0);
`else
    for (int k = 0; k < 80; k++) begin
      n += int'(bus.routeEn);
      tick();
    end
    chk("route_held_no_timeout", n, 80);
    finishRoute(cyc, 1'b0);
`endif

    // Random requests, legal and illegal, with random gaps and router delays.
    for (int t = 0; t < 25; t++) begin
      b = $urandom_range(0, 31);
      l = $urandom_range(0, 34);
      issue(b, l, ok);
      if (ok) begin
        stream(b, l, 2, 1'b1, -1, lb);
        finishRoute(lb + 2 + int'($urandom_range(0, 6)), 1'b0);
      end else begin
        tick();
      end
    end

    repeat (4) tick();
    chk("wr_queue_empty", wrQ.size(), 0);
    chk("route_queue_empty", routeQ.size(), 0);
    chk("done_queue_empty", doneQ.size(), 0);
    chk("error_queue_empty", errQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
